imem_loader: RTL and testbench

Byte-serial program loader that fills the instruction memory before the core runs. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each completed word is written through the instruction-memory write port (WE, W_Addr, W_Ins). While loading, the loader holds the core in reset via `hold`. It sits between the host byte link (UART receiver or testbench) and the fetch stage's write port.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-serial program loader for the instruction memory.
// Accepts a 16-bit big-endian word count N followed by N big-endian 32-bit
// instruction words. Bytes arrive over a valid/ready handshake. Each
// assembled word is written through the instruction-memory write port. The
// core is held in reset while a session runs.
//
// Ports:
//   CLK, RST    clock; synchronous active-high reset
//   start       one-cycle request to begin a session (IDLE/DONE/ERR only)
//   rx_valid    byte on rx_data is valid
//   rx_data     stream byte
//   rx_ready    loader accepts a byte this cycle
//   WE          instruction-memory write enable, one cycle per word
//   W_Addr      byte address of the word being written
//   W_Ins       instruction word being written
//   hold        core reset request while a session is active
//   done        last session completed successfully (level)
//   err         last session rejected for an oversize length (level)
//   word_cnt    words written in the current or last session
module imem_loader #(
  parameter int IMEM_SIZE = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        WE,
  output logic [31:0] W_Addr,
  output logic [31:0] W_Ins,
  output logic        hold,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  // One extra bit keeps the length check unsigned and free of truncation.
  localparam logic [16:0] LIMIT = 17'(IMEM_SIZE);

  logic [2:0]  state;
  logic [15:0] n_len;
  logic [1:0]  idx;
  logic [31:0] asm_word;

  logic        accept;
  logic [15:0] n_full;
  logic [15:0] cnt_next;
  logic [31:0] asm_next;

  always_comb begin
    rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    WE       = (state == WRITE);
    hold     = rx_ready || WE;
    done     = (state == DONE);
    err      = (state == ERR);
    accept   = rx_valid && rx_ready;
    n_full   = {n_len[15:8], rx_data};
    cnt_next = word_cnt + 16'd1;
    asm_next = {asm_word[23:0], rx_data};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      n_len    <= '0;
      idx      <= '0;
      asm_word <= '0;
      W_Addr   <= '0;
      W_Ins    <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN_HI;
            n_len    <= '0;
            idx      <= '0;
            asm_word <= '0;
            W_Addr   <= '0;
            word_cnt <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            n_len[15:8] <= rx_data;
            state       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            n_len[7:0] <= rx_data;
            if (n_full == 16'd0)
              state <= DONE;
            else if ({1'b0, n_full} > LIMIT)
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            asm_word <= asm_next;
            if (idx == 2'd3) begin
              W_Ins <= asm_next;
              idx   <= '0;
              state <= WRITE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        WRITE: begin
          W_Addr   <= W_Addr + 32'd4;
          word_cnt <= cnt_next;
          // Completion is judged on the incremented count.
          state    <= (cnt_next == n_len) ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Ports of the DUT are all connected; write-port activity is logged on the
// falling edge and checked by each scenario task.
module tb_imem_loader;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        WE;
  logic [31:0] W_Addr;
  logic [31:0] W_Ins;
  logic        hold;
  logic        done;
  logic        err;
  logic [15:0] word_cnt;

  int compared;
  int mismatched;
  int unsigned cyc;

  logic [31:0] we_addr[$];
  logic [31:0] we_ins[$];
  int unsigned we_cyc[$];

  imem_loader #(.IMEM_SIZE(64)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .WE(WE), .W_Addr(W_Addr),
    .W_Ins(W_Ins), .hold(hold), .done(done), .err(err), .word_cnt(word_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      we_addr.push_back(W_Addr);
      we_ins.push_back(W_Ins);
      we_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    we_addr.delete();
    we_ins.delete();
    we_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Present a byte, wait (bounded) for the accepting edge, then idle `gap` cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (rx_ready !== 1'b1) begin
      compared++; mismatched++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
    end
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_cycles(2);
    RST = 1'b0;
    @(negedge CLK);
    compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    compared++; if (WE !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %b want 0", WE); end
    compared++; if (hold !== 1'b0) begin mismatched++; $display("FAIL reset_hold: got %b want 0", hold); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
    compared++; if (W_Addr !== 32'h0) begin mismatched++; $display("FAIL reset_waddr: got %h want 0", W_Addr); end
    compared++; if (W_Ins !== 32'h0) begin mismatched++; $display("FAIL reset_wins: got %h want 0", W_Ins); end
    compared++; if (word_cnt !== 16'h0) begin mismatched++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    @(posedge CLK); #1;
  endtask

  task automatic test_two_word(input int gap);
    logic [7:0] bytes [10];
    bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
    clear_log();
    pulse_start();
    @(negedge CLK);
    compared++; if (hold !== 1'b1) begin mismatched++; $display("FAIL start_hold gap=%0d: got %b want 1", gap, hold); end
    compared++; if (rx_ready !== 1'b1) begin mismatched++; $display("FAIL start_rx_ready gap=%0d: got %b want 1", gap, rx_ready); end
    @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[i], gap);
      if (i == 4) begin
        compared++; if (we_addr.size() != 0) begin mismatched++; $display("FAIL partial_word_we gap=%0d: got %0d writes want 0", gap, we_addr.size()); end
      end
    end
    idle_cycles(3);
    @(negedge CLK);
    compared++; if (we_addr.size() != 2) begin mismatched++; $display("FAIL two_word_count gap=%0d: got %0d want 2", gap, we_addr.size()); end
    if (we_addr.size() == 2) begin
      compared++; if (we_addr[0] !== 32'h0) begin mismatched++; $display("FAIL two_word_addr0 gap=%0d: got %h want 0", gap, we_addr[0]); end
      compared++; if (we_ins[0] !== 32'h20080005) begin mismatched++; $display("FAIL two_word_ins0 gap=%0d: got %h want 20080005", gap, we_ins[0]); end
      compared++; if (we_addr[1] !== 32'h4) begin mismatched++; $display("FAIL two_word_addr1 gap=%0d: got %h want 4", gap, we_addr[1]); end
      compared++; if (we_ins[1] !== 32'hAC080004) begin mismatched++; $display("FAIL two_word_ins1 gap=%0d: got %h want ac080004", gap, we_ins[1]); end
      if (gap == 0) begin
        compared++; if (we_cyc[1] - we_cyc[0] != 5) begin mismatched++; $display("FAIL two_word_spacing: got %0d want 5", we_cyc[1] - we_cyc[0]); end
      end
    end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL two_word_done gap=%0d: got %b want 1", gap, done); end
    compared++; if (word_cnt !== 16'd2) begin mismatched++; $display("FAIL two_word_cnt gap=%0d: got %0d want 2", gap, word_cnt); end
    compared++; if (hold !== 1'b0) begin mismatched++; $display("FAIL two_word_hold gap=%0d: got %b want 0", gap, hold); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL two_word_err gap=%0d: got %b want 0", gap, err); end
    @(posedge CLK); #1;
  endtask

  task automatic test_len_bounds();
    // N = 0
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge CLK);
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL len0_done: got %b want 1", done); end
    compared++; if (hold !== 1'b0) begin mismatched++; $display("FAIL len0_hold: got %b want 0", hold); end
    idle_cycles(2);
    compared++; if (we_addr.size() != 0) begin mismatched++; $display("FAIL len0_we: got %0d writes want 0", we_addr.size()); end

    // N = 65, one past capacity
    clear_log();
    pulse_start();
    @(negedge CLK);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL restart_done_clear: got %b want 0", done); end
    @(posedge CLK); #1;
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    @(negedge CLK);
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL len65_err: got %b want 1", err); end
    compared++; if (hold !== 1'b0) begin mismatched++; $display("FAIL len65_hold: got %b want 0", hold); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL len65_done: got %b want 0", done); end
    compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("FAIL len65_rx_ready: got %b want 0", rx_ready); end
    idle_cycles(2);
    compared++; if (we_addr.size() != 0) begin mismatched++; $display("FAIL len65_we: got %0d writes want 0", we_addr.size()); end

    // N = 64, full memory; byte j carries value j mod 256
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    @(negedge CLK);
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL len64_err_clear: got %b want 0", err); end
    @(posedge CLK); #1;
    for (int j = 0; j < 256; j++) send_byte(8'(j), 0);
    idle_cycles(3);
    @(negedge CLK);
    compared++; if (we_addr.size() != 64) begin mismatched++; $display("FAIL len64_count: got %0d want 64", we_addr.size()); end
    if (we_addr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        logic [31:0] exp_ins;
        exp_ins = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        compared++; if (we_addr[i] !== 32'(4*i)) begin mismatched++; $display("FAIL len64_addr[%0d]: got %h want %h", i, we_addr[i], 32'(4*i)); end
        compared++; if (we_ins[i] !== exp_ins) begin mismatched++; $display("FAIL len64_ins[%0d]: got %h want %h", i, we_ins[i], exp_ins); end
      end
      compared++; if (we_addr[63] !== 32'hFC) begin mismatched++; $display("FAIL len64_last_addr: got %h want fc", we_addr[63]); end
    end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL len64_done: got %b want 1", done); end
    compared++; if (word_cnt !== 16'd64) begin mismatched++; $display("FAIL len64_cnt: got %0d want 64", word_cnt); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_word();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    clear_log();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    compared++; if (hold !== 1'b0) begin mismatched++; $display("FAIL midrst_hold: got %b want 0", hold); end
    compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("FAIL midrst_rx_ready: got %b want 0", rx_ready); end
    compared++; if (done !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL midrst_flags: got done=%b err=%b want 0 0", done, err); end
    compared++; if (W_Addr !== 32'h0 || W_Ins !== 32'h0 || word_cnt !== 16'h0) begin mismatched++; $display("FAIL midrst_regs: got addr=%h ins=%h cnt=%0d want 0", W_Addr, W_Ins, word_cnt); end
    // Bytes offered now must not be consumed nor produce a write.
    rx_valid = 1'b1; rx_data = 8'hCC;
    idle_cycles(6);
    rx_valid = 1'b0;
    compared++; if (we_addr.size() != 0) begin mismatched++; $display("FAIL midrst_we: got %0d writes want 0", we_addr.size()); end

    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    idle_cycles(3);
    @(negedge CLK);
    compared++; if (we_addr.size() != 1) begin mismatched++; $display("FAIL after_rst_count: got %0d want 1", we_addr.size()); end
    if (we_addr.size() == 1) begin
      compared++; if (we_addr[0] !== 32'h0) begin mismatched++; $display("FAIL after_rst_addr: got %h want 0", we_addr[0]); end
      compared++; if (we_ins[0] !== 32'h11223344) begin mismatched++; $display("FAIL after_rst_ins: got %h want 11223344", we_ins[0]); end
    end
    compared++; if (done !== 1'b1 || word_cnt !== 16'd1) begin mismatched++; $display("FAIL after_rst_done: got done=%b cnt=%0d want 1 1", done, word_cnt); end
    @(posedge CLK); #1;
  endtask

  task automatic test_start_busy();
    logic [7:0] bytes [10];
    bytes = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[i], 0);
      if (i == 3) pulse_start();
    end
    idle_cycles(3);
    @(negedge CLK);
    compared++; if (we_addr.size() != 2) begin mismatched++; $display("FAIL busy_count: got %0d want 2", we_addr.size()); end
    if (we_addr.size() == 2) begin
      compared++; if (we_ins[0] !== 32'h01020304) begin mismatched++; $display("FAIL busy_ins0: got %h want 01020304", we_ins[0]); end
      compared++; if (we_ins[1] !== 32'h05060708 || we_addr[1] !== 32'h4) begin mismatched++; $display("FAIL busy_word1: got %h@%h want 05060708@4", we_ins[1], we_addr[1]); end
    end
    compared++; if (done !== 1'b1 || word_cnt !== 16'd2) begin mismatched++; $display("FAIL busy_done: got done=%b cnt=%0d want 1 2", done, word_cnt); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    RST        = 1'b1;
    start      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    #1;
    test_reset();
    test_two_word(0);
    test_two_word(3);
    test_len_bounds();
    test_reset_mid_word();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
